// File: rtl/majority_voter_n_pkg.sv
// Shared definitions for the N-channel majority voter: channel health encodings and
// legal parameter ranges.
package majority_voter_n_pkg;

   typedef enum logic [1:0] {
      HS_OK      = 2'd0,
      HS_SUSPECT = 2'd1,
      HS_FAULTED = 2'd2
   } health_e;

   localparam int unsigned CH_MIN = 3;
   localparam int unsigned CH_MAX = 7;

   function automatic bit channels_legal(input int unsigned n);
      return (n >= CH_MIN) && (n <= CH_MAX);
   endfunction

endpackage

// File: rtl/majority_voter_n_bit.sv
// One bit-column of the voter: majority of the active channels' bits, plus a tie flag
// (a tie includes the case of no active channels at all).
module majority_voter_n_bit #(
   parameter int unsigned CHANNELS = 3
) (
   input  logic [CHANNELS-1:0] bits,
   input  logic [CHANNELS-1:0] active,
   output logic                vote_c,
   output logic                tie_c
);

   localparam int unsigned CW = $clog2(CHANNELS + 1) + 1;

   logic [CW-1:0] ones;
   logic [CW-1:0] n_act;
   logic [CW:0]   twice_ones;
   logic [CW:0]   n_act_x;

   always_comb begin
      ones  = '0;
      n_act = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         ones  = ones + CW'(bits[k] & active[k]);
         n_act = n_act + CW'(active[k]);
      end
   end

   assign twice_ones = {ones, 1'b0};
   assign n_act_x    = {1'b0, n_act};
   assign vote_c     = twice_ones > n_act_x;
   assign tie_c      = twice_ones == n_act_x;

endmodule

// File: rtl/majority_voter_n.sv
// Registered N-channel bitwise majority voter with per-channel disagreement tracking
// and sticky fault exclusion.
module majority_voter_n
   import majority_voter_n_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned CHANNELS    = 3,
   parameter int unsigned FAULT_LIMIT = 4,
   parameter int unsigned CNT_W       = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [CHANNELS*WIDTH-1:0] ch_data,
   input  logic [CHANNELS-1:0]       ch_mask,
   input  logic                      clear_fault,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_unanimous,
   output logic                      no_majority,
   output logic [CHANNELS-1:0]       ch_fault
);

   if (!channels_legal(CHANNELS)) begin : g_bad_channels
      $error("majority_voter_n: CHANNELS out of range");
   end
   if (FAULT_LIMIT < 1 || FAULT_LIMIT > (2**CNT_W) - 1) begin : g_bad_limit
      $error("majority_voter_n: FAULT_LIMIT out of range");
   end

   logic [CHANNELS-1:0] fault_c;
   logic [CHANNELS-1:0] active_c;
   logic [CHANNELS-1:0] mismatch_c;
   logic [WIDTH-1:0]    vote_c;
   logic [WIDTH-1:0]    tie_c;
   logic                no_maj_c;
   logic                unan_c;

   assign active_c = ~ch_mask & ~fault_c;
   assign no_maj_c = |tie_c;
   assign unan_c   = (|active_c) & ~|(active_c & mismatch_c);

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [CHANNELS-1:0] col;
      always_comb begin
         col = '0;
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            col[k] = ch_data[k*WIDTH + b];
         end
      end
      majority_voter_n_bit #(.CHANNELS(CHANNELS)) u_bit (
         .bits   (col),
         .active (active_c),
         .vote_c (vote_c[b]),
         .tie_c  (tie_c[b])
      );
   end

   // Per-channel health: consecutive disagreements with the vote of the same sample.
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      health_e          state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign mismatch_c[k] = ch_data[k*WIDTH +: WIDTH] != vote_c;
      assign fault_c[k]    = state_q == HS_FAULTED;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         if (clear_fault) begin
            state_d = HS_OK;
            cnt_d   = '0;
         end else if (in_valid && active_c[k] && !no_maj_c) begin
            if (mismatch_c[k]) begin
               if (cnt_q >= CNT_W'(FAULT_LIMIT - 1)) begin
                  state_d = HS_FAULTED;
                  cnt_d   = CNT_W'(FAULT_LIMIT);
               end else begin
                  state_d = HS_SUSPECT;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = HS_OK;
               cnt_d   = '0;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= HS_OK;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end
   end

   assign ch_fault = fault_c;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_unan_q, out_unan_d;
   logic             no_maj_q, no_maj_d;

   // Result registers hold their last value between valid samples.
   always_comb begin
      out_valid_d = in_valid;
      out_data_d  = out_data_q;
      out_unan_d  = out_unan_q;
      no_maj_d    = no_maj_q;
      if (in_valid) begin
         out_data_d = vote_c;
         out_unan_d = unan_c;
         no_maj_d   = no_maj_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_unan_q  <= 1'b0;
         no_maj_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_unan_q  <= out_unan_d;
         no_maj_q    <= no_maj_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_unanimous = out_unan_q;
   assign no_majority   = no_maj_q;

endmodule

// File: tb/tb_majority_voter_n.sv
// Bench for majority_voter_n (WIDTH=8, CHANNELS=3, FAULT_LIMIT=4): directed scenarios plus
// randomized traffic against a counting reference model.
module tb_majority_voter_n;

   localparam int W     = 8;
   localparam int NCH   = 3;
   localparam int LIMIT = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [NCH*W-1:0]  ch_data = '0;
   logic [NCH-1:0]    ch_mask = '0;
   logic              clear_fault = 1'b0;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic              out_unanimous;
   logic              no_majority;
   logic [NCH-1:0]    ch_fault;

   int checks = 0;
   int errors = 0;

   // reference model state
   int             mcnt [NCH];
   logic [NCH-1:0] mfault;
   logic           exp_valid;
   logic [W-1:0]   exp_data;
   logic           exp_unan;
   logic           exp_nomaj;

   majority_voter_n #(.WIDTH(W), .CHANNELS(NCH), .FAULT_LIMIT(LIMIT), .CNT_W(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .ch_data       (ch_data),
      .ch_mask       (ch_mask),
      .clear_fault   (clear_fault),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_unanimous (out_unanimous),
      .no_majority   (no_majority),
      .ch_fault      (ch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] obs_vec();
      return {out_valid, out_data, out_unanimous, no_majority, ch_fault};
   endfunction

   function automatic logic [13:0] exp_vec();
      return {exp_valid, exp_data, exp_unan, exp_nomaj, mfault};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) mcnt[k] = 0;
      mfault    = '0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_unan  = 1'b0;
      exp_nomaj = 1'b0;
   endtask

   // Count-based model: vote by counting ones, track disagreement runs as integers.
   task automatic model_step(input logic v, input logic [NCH*W-1:0] d,
                             input logic [NCH-1:0] m, input logic clr);
      int   n;
      int   ones;
      bit   act [NCH];
      bit   tie;
      logic [W-1:0] vw;
      n   = 0;
      tie = 1'b0;
      vw  = '0;
      for (int k = 0; k < NCH; k++) begin
         act[k] = !m[k] && !mfault[k];
         if (act[k]) n++;
      end
      if (v) begin
         for (int b = 0; b < W; b++) begin
            ones = 0;
            for (int k = 0; k < NCH; k++) if (act[k] && d[k*W + b]) ones++;
            if (2 * ones > n) vw[b] = 1'b1;
            else if (2 * ones == n) tie = 1'b1;
         end
         exp_data  = vw;
         exp_nomaj = tie;
         exp_unan  = (n > 0);
         for (int k = 0; k < NCH; k++) if (act[k] && d[k*W +: W] != vw) exp_unan = 1'b0;
      end
      exp_valid = v;
      if (clr) begin
         for (int k = 0; k < NCH; k++) mcnt[k] = 0;
         mfault = '0;
      end else if (v && !tie) begin
         for (int k = 0; k < NCH; k++) begin
            if (!act[k]) continue;
            if (d[k*W +: W] != vw) begin
               mcnt[k] = (mcnt[k] + 1 > LIMIT) ? LIMIT : mcnt[k] + 1;
               if (mcnt[k] >= LIMIT) mfault[k] = 1'b1;
            end else begin
               mcnt[k] = 0;
            end
         end
      end
   endtask

   task automatic send(input logic v, input logic [NCH*W-1:0] d,
                       input logic [NCH-1:0] m, input logic clr);
      in_valid    = v;
      ch_data     = d;
      ch_mask     = m;
      clear_fault = clr;
      @(posedge clk);
      #1;
      model_step(v, d, m, clr);
      in_valid    = 1'b0;
      clear_fault = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      clear_fault = 1'b0;
      ch_mask = '0;
      #12;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obs_vec() !== 14'h0) begin
         errors++;
         $display("FAIL reset_state got %h expected %h", obs_vec(), 14'h0);
      end
   endtask

   task automatic test_unanimous();
      do_reset();
      send(1'b1, {3{8'hA5}}, 3'b000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || out_data !== 8'hA5 || out_unanimous !== 1'b1 || no_majority !== 1'b0) begin
         errors++;
         $display("FAIL unanimous got %h expected %h", obs_vec(), exp_vec());
      end
      send(1'b0, {3{8'h00}}, 3'b000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || out_valid !== 1'b0 || out_data !== 8'hA5) begin
         errors++;
         $display("FAIL idle_hold got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_bitwise();
      do_reset();
      send(1'b1, {8'hF0, 8'h0F, 8'hFF}, 3'b000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || out_data !== 8'hFF || out_unanimous !== 1'b0 || ch_fault !== 3'b000) begin
         errors++;
         $display("FAIL bitwise got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_fault();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(1'b1, {8'h00, 8'h3C, 8'h3C}, 3'b000, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec() || ch_fault !== ((i == 3) ? 3'b100 : 3'b000)) begin
            errors++;
            $display("FAIL fault_build sample %0d got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      send(1'b1, {8'h00, 8'hC3, 8'h3C}, 3'b000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || out_data !== 8'h00 || no_majority !== 1'b1 || out_unanimous !== 1'b0) begin
         errors++;
         $display("FAIL fault_tie got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_counter_reset();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(1'b1, (i == 3) ? {3{8'h55}} : {8'h55, 8'hAA, 8'h55}, 3'b000, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec() || ch_fault !== ((i == 7) ? 3'b010 : 3'b000)) begin
            errors++;
            $display("FAIL counter_reset sample %0d got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_clear_fault();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(1'b1, {8'h11, 8'h11, 8'hEE}, 3'b000, (i == 3));
         checks++;
         if (obs_vec() !== exp_vec() || ch_fault !== ((i == 7) ? 3'b001 : 3'b000)) begin
            errors++;
            $display("FAIL clear_fault sample %0d got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int i = 0; i < 4; i++) send(1'b1, {8'h77, 8'h77, 8'h00}, 3'b000, 1'b0);
      in_valid = 1'b1;
      ch_data  = {3{8'h5A}};
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs_vec() !== 14'h0) begin
         errors++;
         $display("FAIL async_reset got %h expected %h", obs_vec(), 14'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send(1'b0, {3{8'h5A}}, 3'b000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL dropped_sample got %h expected %h", obs_vec(), exp_vec());
      end
      send(1'b1, {8'hFF, 8'h12, 8'h34}, 3'b111, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || out_data !== 8'h00 || no_majority !== 1'b1 || out_unanimous !== 1'b0) begin
         errors++;
         $display("FAIL all_masked got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      logic [W-1:0]     base;
      logic [NCH*W-1:0] d;
      logic [NCH-1:0]   m;
      int               r;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         base = W'($urandom);
         for (int k = 0; k < NCH; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7) d[k*W +: W] = base;
            else if (r < 9) d[k*W +: W] = base ^ (W'(1) << $urandom_range(0, W-1));
            else d[k*W +: W] = W'($urandom);
         end
         m = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
         send(($urandom_range(0, 4) != 0), d, m, ($urandom_range(0, 39) == 0));
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random sample %0d got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_unanimous();
      test_bitwise();
      test_fault();
      test_counter_reset();
      test_clear_fault();
      test_reset_midstream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
